// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the floating-point units
package fp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_DIVIDE,
      ST_ROUND,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORMAL,
      CLS_INF,
      CLS_NAN
   } op_class_e;

   // Bit positions inside the 4-bit flags word {invalid, div_by_zero, overflow, underflow}
   localparam int FLAG_INVALID     = 3;
   localparam int FLAG_DIV_BY_ZERO = 2;
   localparam int FLAG_OVERFLOW    = 1;
   localparam int FLAG_UNDERFLOW   = 0;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set; callers truncate to W
   function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
      logic [127:0] r;
      r = ((128'd1 << exp_w) - 128'd1) << man_w;
      r = r | (128'd1 << (man_w - 1));
      return r;
   endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - unpacks one IEEE-754 word into sign/exponent/significand/class
module fp_classify
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] word,
   output logic                 sign,
   output logic [EXP_W-1:0]     exp_f,
   output logic [MAN_W:0]       sig,
   output op_class_e            cls
);

   // Subnormals are treated as zero; the hidden bit is only meaningful for NORMAL
   always_comb begin
      sign  = word[EXP_W+MAN_W];
      exp_f = word[MAN_W +: EXP_W];
      sig   = {1'b1, word[MAN_W-1:0]};
      if (exp_f == '0)
         cls = CLS_ZERO;
      else if (&exp_f)
         cls = (word[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
      else
         cls = CLS_NORMAL;
   end

endmodule

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential restoring IEEE-754 divider with RNE and flags
module fp_div_seq
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [EXP_W+MAN_W:0] result,
   output logic [3:0]           flags
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int S_W   = MAN_W + 1;
   localparam int R_W   = MAN_W + 2;
   localparam int Q_W   = MAN_W + 3;
   localparam int E_W   = EXP_W + 2;
   localparam int CNT_W = $clog2(Q_W + 1);
   localparam logic [W-1:0]          QNAN   = W'(fp_qnan(EXP_W, MAN_W));
   localparam logic signed [E_W-1:0] BIAS_E = E_W'(fp_bias(EXP_W));
   localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);

   state_e                  state;
   logic [W-1:0]            a_r, b_r, res_r;
   logic [3:0]              flg_r;
   logic                    sign_r;
   logic signed [E_W-1:0]   e_r;
   logic [R_W-1:0]          rem_r;
   logic [S_W-1:0]          mb_r;
   logic [Q_W-1:0]          q_r;
   logic [CNT_W-1:0]        cnt_r;

   logic                    sign_a, sign_b, sgn;
   logic [EXP_W-1:0]        exp_a, exp_b;
   logic [S_W-1:0]          sig_a, sig_b;
   op_class_e               cls_a, cls_b;

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
      .word(a_r), .sign(sign_a), .exp_f(exp_a), .sig(sig_a), .cls(cls_a));
   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
      .word(b_r), .sign(sign_b), .exp_f(exp_b), .sig(sig_b), .cls(cls_b));

   assign sgn = sign_a ^ sign_b;

   logic                    spec_hit;
   logic [W-1:0]            spec_res;
   logic [3:0]              spec_flg;

   // Special-operand results decided in PREP; NaN sources take priority over everything
   always_comb begin
      spec_hit = 1'b1;
      spec_res = '0;
      spec_flg = '0;
      if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
          (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
          (cls_a == CLS_INF && cls_b == CLS_INF)) begin
         spec_res = QNAN;
         spec_flg[FLAG_INVALID] = 1'b1;
      end else if (cls_a == CLS_INF) begin
         spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (cls_b == CLS_ZERO) begin
         spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         spec_flg[FLAG_DIV_BY_ZERO] = 1'b1;
      end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
         spec_res = {sgn, {(W-1){1'b0}}};
      end else begin
         spec_hit = 1'b0;
      end
   end

   logic                    div_ge;
   logic [R_W-1:0]          rem_diff, rem_next;

   // One restoring step: subtract when the divisor fits, then shift the remainder
   always_comb begin
      div_ge   = rem_r >= {1'b0, mb_r};
      rem_diff = div_ge ? (rem_r - {1'b0, mb_r}) : rem_r;
      rem_next = {rem_diff[R_W-2:0], 1'b0};
   end

   logic [Q_W-1:0]          q_n;
   logic signed [E_W-1:0]   e_n, e_f;
   logic [S_W-1:0]          sig_n;
   logic [S_W:0]            sig_inc;
   logic [MAN_W-1:0]        frac;
   logic                    guard, sticky, rnd_inc;
   logic [W-1:0]            rnd_res;
   logic [3:0]              rnd_flg;

   // Normalise q into [1,2), round to nearest even, then range-check the exponent
   always_comb begin
      q_n     = q_r[Q_W-1] ? q_r : {q_r[Q_W-2:0], 1'b0};
      e_n     = q_r[Q_W-1] ? e_r : e_r - E_W'(1);
      sig_n   = q_n[Q_W-1 -: S_W];
      guard   = q_n[1];
      sticky  = q_n[0] | (|rem_r);
      rnd_inc = guard & (sticky | sig_n[0]);
      sig_inc = {1'b0, sig_n} + {{S_W{1'b0}}, rnd_inc};
      frac    = sig_inc[S_W] ? sig_inc[MAN_W:1] : sig_inc[MAN_W-1:0];
      e_f     = e_n + {{(E_W-1){1'b0}}, sig_inc[S_W]};
      rnd_flg = '0;
      if (!e_f[E_W-1] && e_f >= E_MAX) begin
         rnd_res = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         rnd_flg[FLAG_OVERFLOW] = 1'b1;
      end else if (e_f[E_W-1] || e_f == '0) begin
         rnd_res = {sign_r, {(W-1){1'b0}}};
         rnd_flg[FLAG_UNDERFLOW] = 1'b1;
      end else begin
         rnd_res = {sign_r, e_f[EXP_W-1:0], frac};
      end
   end

   // Control FSM with registered busy/done/result/flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         flags  <= '0;
         a_r    <= '0;
         b_r    <= '0;
         res_r  <= '0;
         flg_r  <= '0;
         sign_r <= 1'b0;
         e_r    <= '0;
         rem_r  <= '0;
         mb_r   <= '0;
         q_r    <= '0;
         cnt_r  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
                  busy  <= 1'b1;
                  state <= ST_PREP;
               end
            end
            ST_PREP: begin
               sign_r <= sgn;
               if (spec_hit) begin
                  res_r <= spec_res;
                  flg_r <= spec_flg;
                  state <= ST_DONE;
               end else begin
                  e_r   <= $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_E;
                  rem_r <= {1'b0, sig_a};
                  mb_r  <= sig_b;
                  q_r   <= '0;
                  cnt_r <= '0;
                  state <= ST_DIVIDE;
               end
            end
            ST_DIVIDE: begin
               rem_r <= rem_next;
               q_r   <= {q_r[Q_W-2:0], div_ge};
               cnt_r <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_W'(Q_W - 1))
                  state <= ST_ROUND;
            end
            ST_ROUND: begin
               res_r <= rnd_res;
               flg_r <= rnd_flg;
               state <= ST_DONE;
            end
            ST_DONE: begin
               result <= res_r;
               flags  <= flg_r;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Parametrised, multi-cycle IEEE-754 floating-point divider computing `a / b`. It is the sequential successor to the single-precision combinational divider in the floating-point library. It produces one quotient bit per clock using restoring division. It adds a start/done handshake, round-to-nearest-even, special-value handling (zero, infinity, NaN) and exception flags. It sits beside the adder and multiplier units as a shared, low-area divide resource.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: stored fraction width; word width `W = 1 + EXP_W + MAN_W`.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `a` input W: dividend, captured on the accepting edge.
- `b` input W: divisor, captured on the accepting edge.
- `busy` output 1: high from the accepting edge until `done`.
- `done` output 1: one-cycle pulse when `result`/`flags` update.
- `result` output W: quotient; holds until the next `done`.
- `flags` output 4: {invalid, div_by_zero, overflow, underflow}; holds with `result`.

## Operation
- States: IDLE → PREP → DIVIDE → ROUND → DONE → IDLE; PREP → DONE directly for special cases.
- IDLE: `start`=1 latches `a`, `b`, sets `busy`. `start` in any other state is ignored.
- PREP classifies both operands. Exponent field 0 counts as zero (subnormal inputs are flushed, DAZ). All-ones exponent with fraction 0 is inf; with nonzero fraction it is NaN.
- Special results (sign = sa^sb unless NaN):
  - Either operand NaN, 0/0, or inf/inf → canonical qNaN {0, all-ones, 1, zeros}, invalid=1.
  - finite≠0 / 0 → ±inf, div_by_zero=1.
  - inf / finite → ±inf.
  - 0 / nonzero or finite / inf → ±0.
- Normal path in PREP:
  - Significands mA = {1, fracA}, mB = {1, fracB}.
  - Exponent `e = eA − eB + BIAS` in signed EXP_W+2 bits; BIAS = 2^(EXP_W−1) − 1.
  - Remainder is initialised to mA; quotient register `q` is cleared.
- DIVIDE runs Q_W = MAN_W+3 iterations, one per cycle. Each iteration: if rem ≥ mB then {q bit = 1, rem −= mB}; then rem <<= 1 and q <<= 1. The first q bit has weight 1, so q ∈ [0.5, 2).
- ROUND:
  - If q MSB = 0: shift left 1 and decrement e.
  - Significand = top MAN_W+1 bits, guard = next bit, sticky = OR(remaining q bit, rem≠0).
  - RNE: increment when guard & (sticky | lsb). A carry out of the significand shifts right and increments e.
- Range checks on the final e:
  - e ≥ 2^EXP_W − 1 → ±inf, overflow=1.
  - e ≤ 0 → ±0, underflow=1. No subnormal outputs (flush-to-zero).
- DONE drives `done`=1 and `busy`=0, loads `result`/`flags`, and returns to IDLE. A new `start` is accepted on the following edge.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `flags`=0, state IDLE.
- `rst` asserted in any state aborts the operation on that edge. No `done` is issued for the aborted operation.
- Normal-path latency: `done` is high in the cycle following edge k+Q_W+3 after accepting edge k, i.e. 29 edges for the default widths. There is no data dependence.
- Special-case latency: `done` follows edge k+2.
- Throughput: one operation per Q_W+4 cycles; `start` coincident with `done` is ignored.

## Structure
- Package `fp_pkg` holds:
  - State enum.
  - Operand class enum {ZERO, NORMAL, INF, NAN}.
  - Flag bit-index constants.
  - BIAS and canonical-qNaN constant functions of EXP_W/MAN_W.
- Sub-module `fp_classify` (combinational, parametrised) unpacks one operand into sign/exp/significand/class. It is instantiated twice and is reusable by the adder and multiplier units.

## Test plan
- 6.0/2.0: 0x40C00000 / 0x40000000 → 0x40400000, flags 0, `done` 29 edges after `start`.
- 1.0/3.0: 0x3F800000 / 0x40400000 → 0x3EAAAAAB (RNE rounds up). −7.5/2.5: 0xC0F00000 / 0x40200000 → 0xC0400000.
- Special cases, all with latency 2:
  - 1.0/0 → 0x7F800000, div_by_zero.
  - 0/0 → 0x7FC00000, invalid.
  - NaN/1.0 → 0x7FC00000, invalid.
- 0x7F7FFFFF / 0x3E800000 → 0x7F800000, overflow. 0x00800000 / 0x40000000 → 0x00000000, underflow.
- Assert `rst` mid-DIVIDE → next edge `busy`=0, no `done`. A subsequent 6.0/2.0 completes correctly. `start` pulses while busy are ignored.
- Re-run the first two cases with EXP_W=11, MAN_W=52: 0x4018…0 / 0x4000…0 → 0x4008000000000000 at Q_W+3 edges.
